// File: rtl/alu_enc_pkg.sv
// alu_enc_pkg: shared definitions for the ALU instruction encoder.
//   - ALU select codes, R-type funct codes and I-type opcodes
//   - FSM state type, request record and encoder result record
//   - enc_encode(): turns one request into a 32-bit MIPS-style word
package alu_enc_pkg;

  // ALU select codes, as produced by the processor's decoder
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_ILL = 3'b011;
  localparam logic [2:0] SEL_SUB = 3'b100;
  localparam logic [2:0] SEL_SRL = 3'b101;
  localparam logic [2:0] SEL_SLL = 3'b110;
  localparam logic [2:0] SEL_NOR = 3'b111;

  // R-type function codes
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  typedef struct packed {
    logic [2:0]  sel;
    logic        ifmt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        last;
  } enc_req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_word_t;

  // Encode one request; illegal requests return legal=0 and a zero word.
  function automatic enc_word_t enc_encode(input enc_req_t req);
    enc_word_t  res;
    logic [5:0] code;
    logic       shift;
    res.legal = 1'b1;
    res.word  = 32'h0000_0000;
    code      = 6'b000000;
    shift     = 1'b0;
    if (req.ifmt) begin
      case (req.sel)
        SEL_AND: code = OP_ANDI;
        SEL_OR:  code = OP_ORI;
        SEL_ADD: code = OP_ADDI;
        default: res.legal = 1'b0;
      endcase
      if (res.legal) begin
        res.word = {code, req.rs, req.rt, req.imm};
      end else begin
        res.word = 32'h0000_0000;
      end
    end else begin
      case (req.sel)
        SEL_AND: code = FN_AND;
        SEL_OR:  code = FN_OR;
        SEL_ADD: code = FN_ADD;
        SEL_SUB: code = FN_SUB;
        SEL_SRL: begin code = FN_SRL; shift = 1'b1; end
        SEL_SLL: begin code = FN_SLL; shift = 1'b1; end
        SEL_NOR: code = FN_NOR;
        default: res.legal = 1'b0;
      endcase
      if (!res.legal) begin
        res.word = 32'h0000_0000;
      end else if (shift) begin
        // shifts take their operand from rt; rs is a don't-care and is zeroed
        res.word = {OP_RTYPE, 5'd0, req.rt, req.rd, req.shamt, code};
      end else begin
        res.word = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, code};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_req_fifo.sv
// enc_req_fifo: DEPTH-entry request FIFO (DEPTH a power of two, >= 2).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush_i          empties the FIFO
//   push_i, wdata_i  write an entry (accepted when not full, or when popping)
//   pop_i, rdata_o   remove the head entry; rdata_o shows the current head
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries
module enc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (cnt_q == CNT_ZERO);
  assign full_o    = (cnt_q == CNT_FULL);
  assign count_o   = cnt_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: buffers ALU operation requests, encodes each into a
// 32-bit MIPS-style instruction word and writes the words sequentially into
// instruction memory through a we/ack handshake.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_sel, req_ifmt, req_rs, req_rt, req_rd, req_shamt, req_imm, req_last
//                                 request fields
//   clear                         leaves DONE and restarts at BASE_ADDR
//   mem_we/mem_ack                write handshake, mem_we held until mem_ack
//   mem_addr, mem_wdata           word address and encoded instruction
//   done, err_illegal, err_full   status (errors sticky until clear)
//   words_written                 acked-write count, only with ENC_WORD_COUNT_EN
// Optional build macro: ENC_WORD_COUNT_EN
module alu_instr_encoder
  import alu_enc_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_sel,
  input  logic              req_ifmt,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  input  logic              clear,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
`ifdef ENC_WORD_COUNT_EN
  ,
  output logic [ADDR_W:0]   words_written
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  enc_state_e        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_full_q, err_full_d;
  logic              last_q, last_d;
`ifdef ENC_WORD_COUNT_EN
  localparam logic [ADDR_W:0] WORDS_SAT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WORDS_ONE = (ADDR_W+1)'(1);
  logic [ADDR_W:0]   words_q, words_d;
`endif

  enc_req_t          req_in_s, head_s;
  enc_word_t         enc_s;
  logic              fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;
  logic              more_s;

  assign req_in_s    = '{sel: req_sel, ifmt: req_ifmt, rs: req_rs, rt: req_rt,
                         rd: req_rd, shamt: req_shamt, imm: req_imm, last: req_last};
  assign req_ready   = !fifo_full_s && (state_q != ST_DONE);
  assign fifo_push_s = req_valid && req_ready;
  assign enc_s       = enc_encode(head_s);
  // FIFO still holds something once the head popped in ENC is gone
  assign more_s      = (fifo_count_s > CNT_ONE) || fifo_push_s;

  enc_req_fifo #(.DEPTH(DEPTH), .WIDTH($bits(enc_req_t))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fifo_flush_s),
    .push_i  (fifo_push_s),
    .wdata_i (req_in_s),
    .pop_i   (fifo_pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // next-state and output decode
  always_comb begin
    state_d       = state_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    done_d        = done_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;
    last_d        = last_q;
    fifo_pop_s    = 1'b0;
    fifo_flush_s  = 1'b0;
`ifdef ENC_WORD_COUNT_EN
    words_d       = words_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_ENC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENC: begin
        fifo_pop_s = 1'b1;
        if (enc_s.legal) begin
          mem_wdata_d = enc_s.word;
          last_d      = head_s.last;
          mem_we_d    = 1'b1;
          state_d     = ST_WRITE;
        end else if (head_s.last) begin
          err_illegal_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_DONE;
        end else begin
          err_illegal_d = 1'b1;
          state_d       = more_s ? ST_ENC : ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
`ifdef ENC_WORD_COUNT_EN
          if (words_q != WORDS_SAT) begin
            words_d = words_q + WORDS_ONE;
          end else begin
            words_d = words_q;
          end
`endif
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (mem_addr_q == ADDR_MAX) begin
            // no room for another word; stop rather than wrap
            err_full_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
            state_d    = fifo_empty_s ? ST_IDLE : ST_ENC;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        if (clear) begin
          fifo_flush_s  = 1'b1;
          mem_addr_d    = BASE;
          done_d        = 1'b0;
          err_illegal_d = 1'b0;
          err_full_d    = 1'b0;
`ifdef ENC_WORD_COUNT_EN
          words_d       = '0;
`endif
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= BASE;
      mem_wdata_q   <= 32'h0000_0000;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
      last_q        <= 1'b0;
`ifdef ENC_WORD_COUNT_EN
      words_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      done_q        <= done_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
      last_q        <= last_d;
`ifdef ENC_WORD_COUNT_EN
      words_q       <= words_d;
`endif
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign done        = done_q;
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;
`ifdef ENC_WORD_COUNT_EN
  assign words_written = words_q;
`endif

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Program-loader side of the datapath: turns ALU operation requests (3-bit ALU select, format, register fields) into 32-bit MIPS-style instruction words.
- Writes the words sequentially into instruction memory.
- Inverse of the processor's function-code/opcode to ALU-select decode: every word it emits decodes back to the requested select.
- Buffers requests in a small FIFO and drives a handshaked memory write port.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- BASE_ADDR, 0: first write address after reset or clear.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- req_sel  in  3  ALU select
- req_ifmt  in  1  1 = I-type, 0 = R-type
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
- req_imm  in  16  immediate (I-type)
- req_last  in  1  final instruction of program
- clear  in  1  leave DONE, restart at BASE_ADDR
- mem_we  out  1  write request, held until mem_ack
- mem_ack  in  1  write accepted this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- done  out  1  program complete
- err_illegal  out  1  sticky: illegal request dropped
- err_full  out  1  sticky: address space exhausted
- words_written  out  ADDR_W+1  only with ENC_WORD_COUNT_EN

Behaviour:
- Reset values: state IDLE, FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, both error flags 0, req_ready=1.
- req_ready = FIFO not full and state != DONE.
- A push and a pop in the same cycle are legal when the FIFO is full.
- R-type select-to-funct mapping:
  - 000 and 100100; 001 or 100101; 010 add 100000; 100 sub 100010
  - 101 srl 000010; 110 sll 000000; 111 nor 100111; 011 illegal
- R-type word: {000000, rs, rt, rd, shamt, funct}.
  - Shifts: rs forced 0.
  - Non-shifts: shamt forced 0.
- I-type select-to-opcode mapping: 000 andi 001100; 001 ori 001101; 010 addi 001000; all others illegal.
- I-type word: {opcode, rs, rt, imm}.
- FSM:
  - IDLE: FIFO non-empty -> ENC.
  - ENC (1 cycle): pop head, register word.
    - Illegal: set err_illegal, write nothing. Then req_last -> DONE; else FIFO non-empty -> ENC; else IDLE.
    - Legal -> WRITE.
  - WRITE: mem_we=1; mem_addr and mem_wdata stable until mem_ack.
    - On ack, if entry was last -> DONE.
    - Else, if mem_addr is at its maximum: set err_full -> DONE.
    - Else: mem_addr+1, then ENC if FIFO non-empty, else IDLE.
  - DONE: done=1; requests refused.
    - clear -> IDLE, mem_addr=BASE_ADDR, FIFO flushed, flags cleared.
- Latency: accepted request into an empty, idle block -> mem_we asserted 2 cycles later. With immediate acks, sustained throughput is one word per 2 cycles.
- Address never wraps.
- clear outside DONE is ignored.
- reset has priority over everything; mid-write it drops mem_we immediately, and the pending word is lost.

Optional Feature:
- Macro: ENC_WORD_COUNT_EN.
- Defined:
  - words_written counts acked writes.
  - Resets to 0 on reset and on clear.
  - Saturates at 2^ADDR_W.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package alu_enc_pkg holds:
  - select code constants (SEL_AND..SEL_NOR)
  - funct and opcode constants
  - FSM state typedef
- One sub-module, enc_req_fifo: parameterised DEPTH FIFO with full/empty flags.
- The encode function lives in the package.

Test Plan:
- R-type add: sel=010, rs=1, rt=2, rd=3, immediate ack -> mem_wdata=0x00221820 at address 0.
- I-type addi: sel=010, rt=5, imm=7 -> 0x20050007. Then ori: sel=001, rs=1, rt=6, imm=FFFF -> 0x3426FFFF at address 1.
- Shift: sll sel=110, rs=9 (forced 0), rt=2, rd=4, shamt=3 -> 0x000220C0.
- Illegal and last: R-type sel=011 with req_last=1 -> no mem_we, err_illegal=1, done=1; clear -> IDLE with flags 0.
- Backpressure: hold mem_ack=0 for 5 cycles while pushing 5 requests -> req_ready drops after 4 are buffered (DEPTH=4); mem_addr/mem_wdata stable; all 5 words written in order at addresses 0-4.
- ADDR_W=2: push 5 non-last requests -> 4 writes, err_full=1, done=1; with ENC_WORD_COUNT_EN, words_written=4.
